mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Sequencing controller between pipeline stage M and the data-side devices (DM, TIMER0, TIMER1). It accepts one aligned, pre-checked access per handshake, decodes the target, and drives a one-hot device strobe. It waits for the device's ready, enforces a timeout, and returns read data plus a completion/error indication. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `DM_END`, 32'h0000_3000, DM window is [0, DM_END).
- `T0_BASE`, 32'h0000_7F00, TIMER0 window is [T0_BASE, T0_BASE+12).
- `T1_BASE`, 32'h0000_7F10, TIMER1 window is [T1_BASE, T1_BASE+12).
- `TIMEOUT`, 8'd15, maximum BUSY cycles without ready; legal range 1..255.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_addr` in 32: word-aligned address from M.
- `req_ren` in 1: read request.
- `req_wen` in 1: write request.
- `req_byteen` in 4: byte enables.
- `req_wdata` in 32: write data.
- `req_pc` in 32: PC of the requesting instruction.
- `flush` in 1: pipeline flush; blocks acceptance of a new request.
- `stall` out 1: hold stages F..M.
- `done` out 1: one-cycle completion pulse; `rdata`/`buserr` are valid while it is high.
- `rdata` out 32: read result.
- `buserr` out 1: access failed (unmapped address or timeout).
- `err_pc` out 32: `req_pc` latched at acceptance.
- `dev_sel` out 3: one-hot target, {T1,T0,DM}.
- `dev_en` out 1: device strobe.
- `dev_wen` out 1: write qualifier.
- `dev_addr` out 32: latched address.
- `dev_byteen` out 4: latched byte enables.
- `dev_wdata` out 32: latched write data.
- `dm_rdata`, `t0_rdata`, `t1_rdata` in 32: device read data.
- `t0_ready`, `t1_ready` in 1: device completion. DM is implicitly always ready.

## Operation
- A request is valid when `req_ren|req_wen` is high. `req_ren&req_wen` both high is illegal; in that case the write takes priority.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - A valid request with `!flush` is accepted: latch addr, byteen, wdata, wen and pc, and decode the target.
  - Mapped target: load `dev_sel`, clear the timeout counter, go to BUSY.
  - Unmapped target: set `buserr`=1, `rdata`=0, go to RESP with no device strobe.
  - `flush` high: nothing is accepted and the state stays IDLE.
- BUSY:
  - `dev_en`=1 and `dev_wen`=latched wen for every BUSY cycle. A device commits or returns data in the cycle its ready is high.
  - Selected ready high: capture that device's rdata into `rdata` (0 for writes), `buserr`=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`: `buserr`=1, `rdata`=0, go to RESP.
  - `flush` is ignored; an issued bus access always completes.
- RESP: `done`=1 for exactly one cycle, then go to IDLE unconditionally. A new request is never accepted in RESP.
- `stall` = (IDLE & valid & !flush) | BUSY. It is 0 in RESP, so M advances at the end of RESP.
- Counter: 8-bit, saturating, cleared on acceptance.
- `dev_sel`, `dev_en`, `dev_wen`, `dev_addr`, `dev_byteen`, `dev_wdata` are registered outputs, and all are 0 outside BUSY. `dev_addr`/`dev_wdata` hold their latched values until the next accept.

## Timing
- Reset: all outputs are 0 and the state is IDLE. This takes effect immediately when `reset` is asserted, including mid-BUSY; the access is abandoned and no `done` is issued.
- Minimum access length, counting the accept cycle as 0:
  - DM: BUSY in cycle 1, `done` in cycle 2.
  - Timer with ready seen in BUSY cycle k: `done` in cycle k+1.
- Timeout: `done` with `buserr` arrives `TIMEOUT`+1 cycles after accept.
- Unmapped address: `done` with `buserr` in cycle 1.
- Back-to-back DM accesses issue at most one every 3 cycles.
- `rdata`, `buserr` and `err_pc` hold their values after `done` until the next acceptance.

## Test plan
- DM read of 0x0000_0010 with `dm_rdata`=0xDEADBEEF:
  - cycle 0: `stall`=1.
  - cycle 1: `dev_sel`=3'b001, `dev_en`=1.
  - cycle 2: `done`=1, `rdata`=0xDEADBEEF, `stall`=0.
- TIMER0 write of 0x0000_0005 to 0x7F04, with `t0_ready` high in the 3rd BUSY cycle:
  - `dev_wen`=1 for 3 cycles.
  - `done` in cycle 4, `buserr`=0.
- TIMER1 read of 0x7F14 with `t1_ready` held at 0 and `TIMEOUT`=15:
  - `done` in cycle 16 with `buserr`=1, `rdata`=0.
  - `err_pc` equals `req_pc`.
- Unmapped read of 0x0000_5000: `dev_en` never asserts; `done`=1 and `buserr`=1 in cycle 1.
- Flush behaviour:
  - `flush` with a valid request in IDLE: no accept, `stall`=0.
  - `flush` in BUSY: access still completes with `done` after ready.
- `reset` pulsed during the 2nd BUSY cycle: `stall`, `dev_en`, `done` are immediately 0 and the state is IDLE. A following DM read completes normally in 3 cycles.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: bundle between pipeline stage M, the data-side devices
// and mem_bus_ctrl.
//   slave  : controller view (takes requests and device replies, drives
//            stall/done/rdata/buserr/err_pc and the device strobe bus)
//   master : pipeline + device view (the opposite directions)
interface mem_bus_ctrl_if;
  logic [31:0] req_addr;
  logic        req_ren;
  logic        req_wen;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        flush;

  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        buserr;
  logic [31:0] err_pc;

  logic [2:0]  dev_sel;
  logic        dev_en;
  logic        dev_wen;
  logic [31:0] dev_addr;
  logic [3:0]  dev_byteen;
  logic [31:0] dev_wdata;

  logic [31:0] dm_rdata;
  logic [31:0] t0_rdata;
  logic [31:0] t1_rdata;
  logic        t0_ready;
  logic        t1_ready;

  modport slave (
    input  req_addr, req_ren, req_wen, req_byteen, req_wdata, req_pc, flush,
    input  dm_rdata, t0_rdata, t1_rdata, t0_ready, t1_ready,
    output stall, done, rdata, buserr, err_pc,
    output dev_sel, dev_en, dev_wen, dev_addr, dev_byteen, dev_wdata
  );

  modport master (
    output req_addr, req_ren, req_wen, req_byteen, req_wdata, req_pc, flush,
    output dm_rdata, t0_rdata, t1_rdata, t0_ready, t1_ready,
    input  stall, done, rdata, buserr, err_pc,
    input  dev_sel, dev_en, dev_wen, dev_addr, dev_byteen, dev_wdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences one data-side access at a time from stage M to
// DM / TIMER0 / TIMER1. Decodes the target, strobes it until ready or
// timeout, and returns rdata/buserr with a one-cycle done pulse.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mem_bus_ctrl_if.slave (request, stall/done/response, device bus)
module mem_bus_ctrl #(
  parameter logic [31:0] DM_END  = 32'h0000_3000,
  parameter logic [31:0] T0_BASE = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE = 32'h0000_7F10,
  parameter logic [7:0]  TIMEOUT = 8'd15
) (
  input  logic          clk,
  input  logic          reset,
  mem_bus_ctrl_if.slave bus
);

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned NDEV = 3;

  // Window ends computed one bit wider so a base near the top cannot wrap.
  localparam logic [AW:0] T0_END = {1'b0, T0_BASE} + (AW+1)'(12);
  localparam logic [AW:0] T1_END = {1'b0, T1_BASE} + (AW+1)'(12);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q,      state_d;
  logic [CW-1:0]   cnt_q,        cnt_d;
  logic [NDEV-1:0] dev_sel_q,    dev_sel_d;
  logic            dev_en_q,     dev_en_d;
  logic            dev_wen_q,    dev_wen_d;
  logic [AW-1:0]   dev_addr_q,   dev_addr_d;
  logic [BW-1:0]   dev_byteen_q, dev_byteen_d;
  logic [DW-1:0]   dev_wdata_q,  dev_wdata_d;
  logic            done_q,       done_d;
  logic [DW-1:0]   rdata_q,      rdata_d;
  logic            buserr_q,     buserr_d;
  logic [AW-1:0]   err_pc_q,     err_pc_d;

  logic            req_valid;
  logic            accept;
  logic [NDEV-1:0] dec_sel;
  logic            sel_ready;
  logic [DW-1:0]   sel_rdata;
  logic [CW-1:0]   cnt_inc;

  assign req_valid = bus.req_ren | bus.req_wen;
  assign accept    = (state_q == S_IDLE) && req_valid && !bus.flush;

  // Address decode into {T1,T0,DM}; all zero means unmapped.
  always_comb begin
    dec_sel = '0;
    if (bus.req_addr < DM_END) begin
      dec_sel = 3'b001;
    end else if ((bus.req_addr >= T0_BASE) && ({1'b0, bus.req_addr} < T0_END)) begin
      dec_sel = 3'b010;
    end else if ((bus.req_addr >= T1_BASE) && ({1'b0, bus.req_addr} < T1_END)) begin
      dec_sel = 3'b100;
    end
  end

  // DM has no ready line: it completes in its first BUSY cycle.
  assign sel_ready = dev_sel_q[0]
                   | (dev_sel_q[1] & bus.t0_ready)
                   | (dev_sel_q[2] & bus.t1_ready);

  assign sel_rdata = ({DW{dev_sel_q[0]}} & bus.dm_rdata)
                   | ({DW{dev_sel_q[1]}} & bus.t0_rdata)
                   | ({DW{dev_sel_q[2]}} & bus.t1_rdata);

  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dev_sel_d    = dev_sel_q;
    dev_en_d     = dev_en_q;
    dev_wen_d    = dev_wen_q;
    dev_addr_d   = dev_addr_q;
    dev_byteen_d = dev_byteen_q;
    dev_wdata_d  = dev_wdata_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    buserr_d     = buserr_q;
    err_pc_d     = err_pc_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dev_addr_d  = bus.req_addr;
          dev_wdata_d = bus.req_wdata;
          err_pc_d    = bus.req_pc;
          cnt_d       = '0;
          if (dec_sel != '0) begin
            state_d      = S_BUSY;
            dev_sel_d    = dec_sel;
            dev_en_d     = 1'b1;
            dev_wen_d    = bus.req_wen;   // write wins if both ren and wen are set
            dev_byteen_d = bus.req_byteen;
          end else begin
            state_d  = S_RESP;
            done_d   = 1'b1;
            buserr_d = 1'b1;
            rdata_d  = '0;
          end
        end
      end

      S_BUSY: begin
        // flush is deliberately ignored: an issued access always completes.
        if (sel_ready) begin
          state_d  = S_RESP;
          done_d   = 1'b1;
          buserr_d = 1'b0;
          rdata_d  = dev_wen_q ? '0 : sel_rdata;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT) begin
            state_d  = S_RESP;
            done_d   = 1'b1;
            buserr_d = 1'b1;
            rdata_d  = '0;
          end
        end
        if (state_d == S_RESP) begin
          dev_sel_d    = '0;
          dev_en_d     = 1'b0;
          dev_wen_d    = 1'b0;
          dev_byteen_d = '0;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d      = S_IDLE;
        dev_sel_d    = '0;
        dev_en_d     = 1'b0;
        dev_wen_d    = 1'b0;
        dev_byteen_d = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dev_sel_q    <= '0;
      dev_en_q     <= 1'b0;
      dev_wen_q    <= 1'b0;
      dev_addr_q   <= '0;
      dev_byteen_q <= '0;
      dev_wdata_q  <= '0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
      buserr_q     <= 1'b0;
      err_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dev_sel_q    <= dev_sel_d;
      dev_en_q     <= dev_en_d;
      dev_wen_q    <= dev_wen_d;
      dev_addr_q   <= dev_addr_d;
      dev_byteen_q <= dev_byteen_d;
      dev_wdata_q  <= dev_wdata_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      buserr_q     <= buserr_d;
      err_pc_q     <= err_pc_d;
    end
  end

  // stall must see the current request to freeze M in the accept cycle;
  // reset forces it low immediately.
  assign bus.stall = !reset && (accept || (state_q == S_BUSY));

  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.buserr     = buserr_q;
  assign bus.err_pc     = err_pc_q;
  assign bus.dev_sel    = dev_sel_q;
  assign bus.dev_en     = dev_en_q;
  assign bus.dev_wen    = dev_wen_q;
  assign bus.dev_addr   = dev_addr_q;
  assign bus.dev_byteen = dev_byteen_q;
  assign bus.dev_wdata  = dev_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 units after the edge.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl_if bus();

  mem_bus_ctrl #(
    .DM_END (32'h0000_3000),
    .T0_BASE(32'h0000_7F00),
    .T1_BASE(32'h0000_7F10),
    .TIMEOUT(8'd15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_req();
    bus.req_addr   = '0;
    bus.req_ren    = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_byteen = '0;
    bus.req_wdata  = '0;
    bus.req_pc     = '0;
    bus.flush      = 1'b0;
    bus.t0_ready   = 1'b0;
    bus.t1_ready   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_req();
    bus.dm_rdata = '0;
    bus.t0_rdata = '0;
    bus.t1_rdata = '0;
    #12;
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h10;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", bus.done); end
    total++; if (bus.dev_en !== 1'b0) begin bad++; $display("FAIL rst_dev_en: got %0b want 0", bus.dev_en); end
    total++; if (bus.dev_sel !== 3'b000) begin bad++; $display("FAIL rst_dev_sel: got %b want 000", bus.dev_sel); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    total++; if (bus.buserr !== 1'b0) begin bad++; $display("FAIL rst_buserr: got %0b want 0", bus.buserr); end
    total++; if (bus.err_pc !== 32'h0) begin bad++; $display("FAIL rst_err_pc: got %h want 0", bus.err_pc); end
    clear_req();
    next_cyc();
    reset = 1'b0;
    next_cyc();
  endtask

  task automatic test_dm_read();
    clear_req();
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h0000_0010;
    bus.req_pc   = 32'h0000_0100;
    bus.dm_rdata = 32'hDEAD_BEEF;
    settle();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL dm_c0_stall: got %0b want 1", bus.stall); end
    total++; if (bus.dev_en !== 1'b0) begin bad++; $display("FAIL dm_c0_dev_en: got %0b want 0", bus.dev_en); end
    next_cyc(); settle();
    total++; if (bus.dev_sel !== 3'b001) begin bad++; $display("FAIL dm_c1_dev_sel: got %b want 001", bus.dev_sel); end
    total++; if (bus.dev_en !== 1'b1) begin bad++; $display("FAIL dm_c1_dev_en: got %0b want 1", bus.dev_en); end
    total++; if (bus.dev_wen !== 1'b0) begin bad++; $display("FAIL dm_c1_dev_wen: got %0b want 0", bus.dev_wen); end
    total++; if (bus.dev_addr !== 32'h10) begin bad++; $display("FAIL dm_c1_dev_addr: got %h want 10", bus.dev_addr); end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL dm_c1_stall: got %0b want 1", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL dm_c1_done: got %0b want 0", bus.done); end
    next_cyc(); settle();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL dm_c2_done: got %0b want 1", bus.done); end
    total++; if (bus.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dm_c2_rdata: got %h want deadbeef", bus.rdata); end
    total++; if (bus.buserr !== 1'b0) begin bad++; $display("FAIL dm_c2_buserr: got %0b want 0", bus.buserr); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL dm_c2_stall: got %0b want 0", bus.stall); end
    total++; if (bus.dev_en !== 1'b0) begin bad++; $display("FAIL dm_c2_dev_en: got %0b want 0", bus.dev_en); end
    total++; if (bus.dev_sel !== 3'b000) begin bad++; $display("FAIL dm_c2_dev_sel: got %b want 000", bus.dev_sel); end
    next_cyc();
    clear_req();
    settle();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL dm_c3_done: got %0b want 0", bus.done); end
    total++; if (bus.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dm_c3_rdata_hold: got %h want deadbeef", bus.rdata); end
    total++; if (bus.err_pc !== 32'h100) begin bad++; $display("FAIL dm_c3_err_pc: got %h want 100", bus.err_pc); end
    total++; if (bus.dev_addr !== 32'h10) begin bad++; $display("FAIL dm_c3_dev_addr_hold: got %h want 10", bus.dev_addr); end
  endtask

  task automatic test_unmapped();
    logic [31:0] ua [4];
    ua[0] = 32'h0000_5000;
    ua[1] = 32'h0000_3000;
    ua[2] = 32'h0000_7F0C;
    ua[3] = 32'h0000_7F1C;
    for (int i = 0; i < 4; i++) begin
      clear_req();
      bus.req_ren  = 1'b1;
      bus.req_addr = ua[i];
      bus.req_pc   = 32'h400 + 32'(i);
      settle();
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL um%0d_c0_stall: got %0b want 1", i, bus.stall); end
      next_cyc(); settle();
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL um%0d_done: got %0b want 1", i, bus.done); end
      total++; if (bus.buserr !== 1'b1) begin bad++; $display("FAIL um%0d_buserr: got %0b want 1", i, bus.buserr); end
      total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL um%0d_rdata: got %h want 0", i, bus.rdata); end
      total++; if (bus.dev_en !== 1'b0) begin bad++; $display("FAIL um%0d_dev_en: got %0b want 0", i, bus.dev_en); end
      total++; if (bus.err_pc !== 32'h400 + 32'(i)) begin bad++; $display("FAIL um%0d_err_pc: got %h want %h", i, bus.err_pc, 32'h400 + 32'(i)); end
      next_cyc();
      clear_req();
      settle();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL um%0d_done_clear: got %0b want 0", i, bus.done); end
      total++; if (bus.buserr !== 1'b1) begin bad++; $display("FAIL um%0d_buserr_hold: got %0b want 1", i, bus.buserr); end
    end
  endtask

  task automatic test_timer0_write();
    clear_req();
    bus.req_wen    = 1'b1;
    bus.req_addr   = 32'h0000_7F04;
    bus.req_wdata  = 32'h0000_0005;
    bus.req_byteen = 4'hF;
    bus.req_pc     = 32'h200;
    bus.t0_rdata   = 32'hFFFF_0000;
    settle();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL t0w_c0_stall: got %0b want 1", bus.stall); end
    for (int k = 1; k <= 3; k++) begin
      next_cyc();
      if (k == 3) bus.t0_ready = 1'b1;
      settle();
      total++; if (bus.dev_wen !== 1'b1) begin bad++; $display("FAIL t0w_c%0d_dev_wen: got %0b want 1", k, bus.dev_wen); end
      total++; if (bus.dev_sel !== 3'b010) begin bad++; $display("FAIL t0w_c%0d_dev_sel: got %b want 010", k, bus.dev_sel); end
      total++; if (bus.dev_wdata !== 32'h5) begin bad++; $display("FAIL t0w_c%0d_dev_wdata: got %h want 5", k, bus.dev_wdata); end
      total++; if (bus.dev_byteen !== 4'hF) begin bad++; $display("FAIL t0w_c%0d_dev_byteen: got %h want f", k, bus.dev_byteen); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL t0w_c%0d_done: got %0b want 0", k, bus.done); end
    end
    next_cyc();
    bus.t0_ready = 1'b0;
    settle();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL t0w_c4_done: got %0b want 1", bus.done); end
    total++; if (bus.buserr !== 1'b0) begin bad++; $display("FAIL t0w_c4_buserr: got %0b want 0", bus.buserr); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL t0w_c4_rdata: got %h want 0", bus.rdata); end
    total++; if (bus.dev_wen !== 1'b0) begin bad++; $display("FAIL t0w_c4_dev_wen: got %0b want 0", bus.dev_wen); end
    total++; if (bus.dev_byteen !== 4'h0) begin bad++; $display("FAIL t0w_c4_dev_byteen: got %h want 0", bus.dev_byteen); end
    next_cyc();
    clear_req();
  endtask

  task automatic test_timeout();
    int done_cyc = -1;
    int en_cnt   = 0;
    clear_req();
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h0000_7F14;
    bus.req_pc   = 32'h300;
    bus.t1_rdata = 32'h1234_5678;
    for (int c = 1; c <= 40; c++) begin
      next_cyc(); settle();
      if (bus.dev_en === 1'b1) en_cnt++;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    total++; if (done_cyc != 16) begin bad++; $display("FAIL to_done_cycle: got %0d want 16", done_cyc); end
    total++; if (en_cnt != 15) begin bad++; $display("FAIL to_busy_cycles: got %0d want 15", en_cnt); end
    total++; if (bus.buserr !== 1'b1) begin bad++; $display("FAIL to_buserr: got %0b want 1", bus.buserr); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", bus.rdata); end
    total++; if (bus.err_pc !== 32'h300) begin bad++; $display("FAIL to_err_pc: got %h want 300", bus.err_pc); end
    next_cyc();
    clear_req();
  endtask

  task automatic test_flush();
    clear_req();
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h20;
    bus.flush    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fl_idle%0d_stall: got %0b want 0", k, bus.stall); end
      total++; if (bus.dev_en !== 1'b0) begin bad++; $display("FAIL fl_idle%0d_dev_en: got %0b want 0", k, bus.dev_en); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL fl_idle%0d_done: got %0b want 0", k, bus.done); end
      next_cyc();
    end
    bus.flush    = 1'b0;
    bus.req_addr = 32'h0000_7F00;
    bus.req_pc   = 32'h500;
    bus.t0_rdata = 32'hCAFE_0001;
    settle();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL fl_c0_stall: got %0b want 1", bus.stall); end
    next_cyc();
    bus.flush = 1'b1;
    settle();
    total++; if (bus.dev_en !== 1'b1) begin bad++; $display("FAIL fl_c1_dev_en: got %0b want 1", bus.dev_en); end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL fl_c1_stall: got %0b want 1", bus.stall); end
    next_cyc();
    bus.t0_ready = 1'b1;
    settle();
    total++; if (bus.dev_en !== 1'b1) begin bad++; $display("FAIL fl_c2_dev_en: got %0b want 1", bus.dev_en); end
    next_cyc();
    bus.t0_ready = 1'b0;
    settle();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fl_c3_done: got %0b want 1", bus.done); end
    total++; if (bus.rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL fl_c3_rdata: got %h want cafe0001", bus.rdata); end
    total++; if (bus.buserr !== 1'b0) begin bad++; $display("FAIL fl_c3_buserr: got %0b want 0", bus.buserr); end
    next_cyc();
    clear_req();
  endtask

  task automatic test_reset_mid_busy();
    clear_req();
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h0000_7F08;
    bus.req_pc   = 32'h600;
    next_cyc();
    next_cyc(); settle();
    total++; if (bus.dev_en !== 1'b1) begin bad++; $display("FAIL rmb_busy2_dev_en: got %0b want 1", bus.dev_en); end
    reset = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rmb_stall: got %0b want 0", bus.stall); end
    total++; if (bus.dev_en !== 1'b0) begin bad++; $display("FAIL rmb_dev_en: got %0b want 0", bus.dev_en); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmb_done: got %0b want 0", bus.done); end
    total++; if (bus.dev_sel !== 3'b000) begin bad++; $display("FAIL rmb_dev_sel: got %b want 000", bus.dev_sel); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rmb_rdata: got %h want 0", bus.rdata); end
    total++; if (bus.err_pc !== 32'h0) begin bad++; $display("FAIL rmb_err_pc: got %h want 0", bus.err_pc); end
    next_cyc();
    reset = 1'b0;
    clear_req();
    next_cyc();
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h0000_2FFC;
    bus.req_pc   = 32'h700;
    bus.dm_rdata = 32'h0BAD_F00D;
    settle();
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rmb_dm_c0_stall: got %0b want 1", bus.stall); end
    next_cyc(); settle();
    total++; if (bus.dev_sel !== 3'b001) begin bad++; $display("FAIL rmb_dm_c1_dev_sel: got %b want 001", bus.dev_sel); end
    next_cyc(); settle();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rmb_dm_c2_done: got %0b want 1", bus.done); end
    total++; if (bus.rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL rmb_dm_c2_rdata: got %h want 0badf00d", bus.rdata); end
    next_cyc();
    clear_req();
  endtask

  task automatic test_write_priority();
    clear_req();
    bus.req_ren   = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hA5;
    bus.dm_rdata  = 32'h1111_2222;
    next_cyc(); settle();
    total++; if (bus.dev_wen !== 1'b1) begin bad++; $display("FAIL wp_dev_wen: got %0b want 1", bus.dev_wen); end
    next_cyc(); settle();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL wp_done: got %0b want 1", bus.done); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL wp_rdata: got %h want 0", bus.rdata); end
    next_cyc();
    clear_req();
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    clear_req();
    bus.req_ren  = 1'b1;
    bus.req_addr = 32'h80;
    bus.dm_rdata = 32'h77;
    for (int c = 0; c < 9; c++) begin
      settle();
      exp_done = ((c % 3) == 2);
      total++; if (bus.done !== exp_done) begin bad++; $display("FAIL b2b_c%0d_done: got %0b want %0b", c, bus.done, exp_done); end
      next_cyc();
    end
    clear_req();
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dm_read();
    test_unmapped();
    test_timer0_write();
    test_timeout();
    test_flush();
    test_reset_mid_busy();
    test_write_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
